// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with prioritised redirects, stall-latched redirect slot,
// and an optional return-address stack built only when PC_RAS_EN is defined.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter int                 STEP         = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h80),
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCwriteEn,
    input  logic             exc_req,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] PC_next_seq,
    output logic             redirect_pending,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow
);
    localparam logic [WIDTH-1:0] MASK = ~(WIDTH'(STEP) - WIDTH'(1));

    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] x);
        return x & MASK;
    endfunction

    logic [WIDTH-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
    logic             pend_q, pend_d, pend_exc_q, pend_exc_d;
    logic             ras_act, ras_hit;
    logic [WIDTH-1:0] ras_top;

    assign PC_out           = pc_q;
    assign PC_next_seq      = pc_q + WIDTH'(STEP);
    assign redirect_pending = pend_q;
    assign ras_act          = PCwriteEn && !exc_req && !pend_q && !branch_taken;

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_exc_d = pend_exc_q;
        pend_pc_d  = pend_pc_q;
        if (PCwriteEn) begin
            pc_d = exc_req      ? align(EXC_VECTOR)    :
                   pend_q       ? pend_pc_q            :
                   branch_taken ? align(branch_target) :
                   jump_en      ? align(jump_target)   :
                   ras_hit      ? ras_top              : PC_next_seq;
            pend_d     = 1'b0;
            pend_exc_d = 1'b0;
        end else if (exc_req) begin
            pend_d     = 1'b1;
            pend_exc_d = 1'b1;
            pend_pc_d  = align(EXC_VECTOR);
        end else if ((branch_taken || jump_en) && !(pend_q && pend_exc_q)) begin
            // a latched exception is never displaced by a later branch or jump
            pend_d     = 1'b1;
            pend_exc_d = 1'b0;
            pend_pc_d  = branch_taken ? align(branch_target) : align(jump_target);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_exc_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_exc_q <= pend_exc_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int            AW   = $clog2(RAS_DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] stk_q [RAS_DEPTH];
    logic [WIDTH-1:0] stk_d [RAS_DEPTH];
    logic [AW-1:0]    tp_q, tp_d, tp_pop;
    logic [AW:0]      cnt_q, cnt_d, cnt_pop;
    logic             uf_q, uf_d, pop, push;

    assign pop           = ras_act && ret_en;
    assign push          = ras_act && call_en;
    assign ras_hit       = pop && cnt_q != '0;
    assign ras_top       = stk_q[tp_q];
    assign ras_empty     = cnt_q == '0;
    assign ras_full      = cnt_q == FULL;
    assign ras_underflow = uf_q;

    // circular stack: pushing when full advances over the oldest entry
    always_comb begin
        stk_d   = stk_q;
        tp_pop  = ras_hit ? tp_q - AW'(1) : tp_q;
        cnt_pop = ras_hit ? cnt_q - (AW+1)'(1) : cnt_q;
        tp_d    = push ? tp_pop + AW'(1) : tp_pop;
        cnt_d   = (push && cnt_pop != FULL) ? cnt_pop + (AW+1)'(1) : cnt_pop;
        uf_d    = pop && cnt_q == '0;
        if (push) stk_d[tp_d] = PC_next_seq;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stk_q <= '{default: '0};
            tp_q  <= '0;
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            stk_q <= stk_d;
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end
`else
    logic unused_ras;

    assign ras_hit       = 1'b0;
    assign ras_top       = '0;
    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
    assign ras_underflow = 1'b0;
    assign unused_ras    = call_en ^ ret_en ^ ras_act;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors feed a scoreboard queue; a negedge monitor pops and checks.
module tb_pc_unit;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        PCwriteEn = 1'b0, exc_req = 1'b0, branch_taken = 1'b0, jump_en = 1'b0;
    logic        call_en = 1'b0, ret_en = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic [31:0] PC_out, PC_next_seq;
    logic        redirect_pending, ras_empty, ras_full, ras_underflow;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        pend, empty, full, uf;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, step_id = 0;

    pc_unit dut (
        .clk(clk), .reset(reset), .PCwriteEn(PCwriteEn), .exc_req(exc_req),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_en(jump_en), .jump_target(jump_target), .call_en(call_en), .ret_en(ret_en),
        .PC_out(PC_out), .PC_next_seq(PC_next_seq), .redirect_pending(redirect_pending),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h expected %h", id, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.id, "PC_out", PC_out, e.pc);
            chk(e.id, "PC_next_seq", PC_next_seq, e.pc + 32'd4);
            chk(e.id, "redirect_pending", 32'(redirect_pending), 32'(e.pend));
            chk(e.id, "ras_empty", 32'(ras_empty), 32'(e.empty));
            chk(e.id, "ras_full", 32'(ras_full), 32'(e.full));
            chk(e.id, "ras_underflow", 32'(ras_underflow), 32'(e.uf));
        end
    end

    task automatic expect_now(input logic [31:0] pc, input logic pend, empty, full, uf);
        step_id++;
        sb.push_back('{step_id, pc, pend, empty, full, uf});
    endtask

    task automatic drive(input logic we, exc, br, input logic [31:0] bt, input logic jp,
                         input logic [31:0] jt, input logic call, ret,
                         input logic [31:0] pc, input logic pend, empty, full, uf);
        @(negedge clk);
        PCwriteEn = we; exc_req = exc; branch_taken = br; branch_target = bt;
        jump_en = jp; jump_target = jt; call_en = call; ret_en = ret;
        @(posedge clk);
        #1 expect_now(pc, pend, empty, full, uf);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 expect_now(32'h0, 0, 1, 0, 0);
        @(negedge clk) reset = 1'b0;
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h4,        0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h8,        0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'hC,        0, 1, 0, 0);
        drive(0, 0, 1, 32'h40,  0, 32'h0,        0, 0, 32'hC,        1, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h40,       0, 1, 0, 0);
        drive(1, 1, 1, 32'h200, 1, 32'h300,      0, 0, 32'h80,       0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0);
        drive(1, 0, 1, 32'h43,  0, 32'h0,        0, 0, 32'h40,       0, 1, 0, 0);
        drive(0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h40,       1, 1, 0, 0);
        drive(0, 0, 1, 32'h200, 0, 32'h0,        0, 0, 32'h40,       1, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h80,       0, 1, 0, 0);
        drive(0, 0, 0, 32'h0,   1, 32'h300,      0, 0, 32'h80,       1, 1, 0, 0);
        drive(0, 0, 1, 32'h400, 1, 32'h500,      0, 0, 32'h80,       1, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   1, 32'h600,      0, 0, 32'h400,      0, 1, 0, 0);
        drive(0, 0, 1, 32'h100, 0, 32'h0,        0, 0, 32'h400,      1, 1, 0, 0);
        drive(1, 1, 0, 32'h0,   0, 32'h0,        0, 0, 32'h80,       0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h84,       0, 1, 0, 0);
        drive(0, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h84,       0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   1, 32'h10,       0, 0, 32'h10,       0, 1, 0, 0);
`ifdef PC_RAS_EN
        drive(1, 0, 0, 32'h0,   1, 32'h100,      1, 0, 32'h100,      0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h14,       0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h18,       0, 1, 0, 1);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 0, 32'h1C,       0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   1, 32'h200,      1, 0, 32'h200,      0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,   1, 32'h300,      1, 0, 32'h300,      0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,   1, 32'h400,      1, 0, 32'h400,      0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,   1, 32'h500,      1, 0, 32'h500,      0, 0, 1, 0);
        drive(1, 0, 0, 32'h0,   1, 32'h600,      1, 0, 32'h600,      0, 0, 1, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h504,      0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h404,      0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h304,      0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h204,      0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h208,      0, 1, 0, 1);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        1, 0, 32'h20C,      0, 0, 0, 0);
        drive(1, 0, 0, 32'h0,   1, 32'h800,      0, 1, 32'h800,      0, 1, 0, 0);
        drive(0, 0, 0, 32'h0,   0, 32'h0,        1, 0, 32'h800,      0, 1, 0, 0);
`else
        drive(1, 0, 0, 32'h0,   1, 32'h100,      1, 0, 32'h100,      0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        0, 1, 32'h104,      0, 1, 0, 0);
        drive(1, 0, 0, 32'h0,   0, 32'h0,        1, 0, 32'h108,      0, 1, 0, 0);
`endif
        drive(1, 0, 0, 32'h0,   1, 32'h900,      1, 0, 32'h900,      0, !RAS, 0, 0);
        drive(0, 0, 1, 32'h40,  0, 32'h0,        0, 0, 32'h900,      1, !RAS, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 expect_now(32'h0, 0, 1, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
